// File: rtl/gray_count_decoder.sv
// Gray-count decoder: synchronizes an external Gray count, decodes it to
// binary and tracks +1 steps, wraps and illegal transitions.
//
// Ports:
//   Clk             - sole clock, rising edge
//   Clear_in        - asynchronous active-high reset
//   GrayCount_in    - Gray count from an external counter (unsynchronized)
//   Enable_in       - sample qualifier for the decode/compare stage
//   Resync_in       - re-prime tracking and clear Error_out
//   BinaryCount_out - binary decode of the last enabled sample
//   Step_out        - one-cycle pulse on a valid +1 advance (TRACK only)
//   Wrap_out        - one-cycle pulse on a valid all-ones -> zero advance
//   Error_out       - high while in FAULT
//   ErrorCount_out  - saturating count of illegal transitions

module gray_count_decoder #(
  parameter int COUNTER_WIDTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     Clk,
  input  logic                     Clear_in,
  input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
  input  logic                     Enable_in,
  input  logic                     Resync_in,
  output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
  output logic                     Step_out,
  output logic                     Wrap_out,
  output logic                     Error_out,
  output logic [7:0]               ErrorCount_out
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  generate
    if (W < 2 || W > 16) begin : g_bad_width
      $error("COUNTER_WIDTH out of range 2..16");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES out of range 2..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_PRIME,
    ST_TRACK,
    ST_FAULT
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronizer: shifts every cycle, independent of Enable_in
  // ---------------------------------------------------------------
  logic [W-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= GrayCount_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  logic [W-1:0] w_g;
  assign w_g = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Gray -> binary: bit i is the XOR of all Gray bits at or above i
  // ---------------------------------------------------------------
  logic [W-1:0] w_bin;

  always_comb begin
    w_bin = '0;
    for (int i = 0; i < W; i++) begin
      w_bin[i] = ^(w_g >> i);
    end
  end

  // ---------------------------------------------------------------
  // Transition classification against the previous enabled sample
  // ---------------------------------------------------------------
  logic [W-1:0] r_prev_g;
  logic [W-1:0] r_prev_b;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_delta;
  logic         w_hold;
  logic         w_one;
  logic         w_adv;
  logic         w_wrap;
  logic         w_illegal;

  assign w_diff  = w_g ^ r_prev_g;
  assign w_delta = w_bin - r_prev_b;
  assign w_hold  = (w_diff == '0);
  // exactly one bit set: non-zero and clearing the lowest set bit
  // leaves nothing behind
  assign w_one   = !w_hold && ((w_diff & (w_diff - ONE)) == '0);
  assign w_adv   = w_one && (w_delta == ONE);
  assign w_wrap  = w_adv && (r_prev_b == '1);
  // anything that is neither a hold nor a +1 advance is illegal,
  // including reverse steps and multi-bit jumps
  assign w_illegal = !w_hold && !w_adv;

  // ---------------------------------------------------------------
  // Mutually exclusive action selects for the tracking FSM
  // ---------------------------------------------------------------
  state_t r_state;
  logic   w_load;
  logic   w_bad;
  logic   w_good;
  logic   w_rearm;
  logic   w_keep;

  assign w_load  = Enable_in && (Resync_in || r_state == ST_PRIME);
  assign w_bad   = Enable_in && !w_load && w_illegal;
  assign w_good  = Enable_in && !w_load && !w_illegal;
  assign w_rearm = !Enable_in && Resync_in;
  assign w_keep  = !Enable_in && !Resync_in;

  logic [W-1:0] r_bin;
  logic         r_step;
  logic         r_wrap;
  logic         r_error;
  logic [7:0]   r_err_cnt;

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_state   <= ST_PRIME;
      r_prev_g  <= '0;
      r_prev_b  <= '0;
      r_bin     <= '0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
      r_error   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (Enable_in) begin
        r_bin    <= w_bin;
        r_prev_g <= w_g;
        r_prev_b <= w_bin;
      end
      unique case (1'b1)
        w_load: begin
          // priming sample: loaded without any compare
          r_state <= ST_TRACK;
          r_error <= 1'b0;
        end
        w_bad: begin
          r_state <= ST_FAULT;
          r_error <= 1'b1;
          if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        w_good: begin
          // holds and advances keep the state; pulses only in TRACK
          if (w_adv && r_state == ST_TRACK) begin
            r_step <= 1'b1;
            r_wrap <= w_wrap;
          end
        end
        w_rearm: begin
          r_state <= ST_PRIME;
          r_error <= 1'b0;
        end
        w_keep: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign BinaryCount_out = r_bin;
  assign Step_out        = r_step;
  assign Wrap_out        = r_wrap;
  assign Error_out       = r_error;
  assign ErrorCount_out  = r_err_cnt;

endmodule
